qam_frame_sequencer: RTL

//   Frame-level controller for the QAM modulator chain (m-sequence source -> serial/parallel -> I/Q level mapping).
//   On start, sequences one burst: seed-load the m-sequence generator, emit a fixed preamble, gate PAYLOAD_LEN payload

---
 rtl/qam_frame_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/qam_frame_sequencer.sv
// qam_frame_sequencer
// Frame-level controller for the QAM modulator chain. A burst is a seed load of
// the m-sequence generator, then a fixed preamble, then payload symbols taken
// from the m-sequence path, then a guard interval, and finally a one-cycle done
// pulse. Symbol pacing comes from the sym_tick enable strobe. The whole block
// runs on the single system clock.
module qam_frame_sequencer #(
   parameter int         LEN_W     = 8,
   parameter int         PRE_LEN   = 8,
   parameter int         GUARD_LEN = 4,
   parameter logic [2:0] SEED      = 3'b001
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             sym_tick,
   input  logic [LEN_W-1:0] payload_len,
   output logic             busy,
   output logic             done,
   output logic             tx_valid,
   output logic [1:0]       sym_sel,
   output logic [1:0]       pre_i,
   output logic [1:0]       pre_q,
   output logic             m_load,
   output logic [2:0]       m_seed,
   output logic             m_en,
   output logic [LEN_W-1:0] sym_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_PRE, S_PAY, S_GUARD, S_DONE
   } state_t;

   // Last symbol index of the fixed-length phases. The value is never used
   // when the matching phase length is zero.
   localparam logic [LEN_W-1:0] PRE_LAST   = LEN_W'(PRE_LEN - 1);
   localparam logic [LEN_W-1:0] GUARD_LAST = LEN_W'(GUARD_LEN - 1);

   state_t           state_reg, state_next;
   logic [LEN_W-1:0] cnt_reg, cnt_next;
   logic [LEN_W-1:0] len_reg, len_next;

   state_t           after_pay;
   state_t           after_pre;
   state_t           after_load;

   logic             busy_next, done_next, tx_valid_next, m_load_next, m_en_next;
   logic [1:0]       sym_sel_next, pre_i_next, pre_q_next;
   logic [2:0]       m_seed_next;
   logic [LEN_W-1:0] sym_cnt_next;

   // Empty phases are skipped. These signals give the first non-empty phase
   // that follows each point in the frame.
   always_comb begin
      after_pay  = (GUARD_LEN != 0) ? S_GUARD : S_DONE;
      after_pre  = (len_reg != '0) ? S_PAY : after_pay;
      after_load = (PRE_LEN != 0) ? S_PRE : after_pre;
   end

   // Next state, phase counter and latched payload length. abort takes priority over all other inputs.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      len_next   = len_reg;
      if (abort) begin
         state_next = S_IDLE;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  len_next   = payload_len;
                  state_next = S_LOAD;
                  cnt_next   = '0;
               end
            end
            S_LOAD: begin
               cnt_next   = '0;
               state_next = after_load;
            end
            S_PRE: begin
               if (sym_tick) begin
                  if (cnt_reg == PRE_LAST) begin
                     cnt_next   = '0;
                     state_next = after_pre;
                  end else begin
                     cnt_next = cnt_reg + LEN_W'(1);
                  end
               end
            end
            S_PAY: begin
               if (sym_tick) begin
                  if (cnt_reg == len_reg - LEN_W'(1)) begin
                     cnt_next   = '0;
                     state_next = after_pay;
                  end else begin
                     cnt_next = cnt_reg + LEN_W'(1);
                  end
               end
            end
            S_GUARD: begin
               if (sym_tick) begin
                  if (cnt_reg == GUARD_LAST) begin
                     cnt_next   = '0;
                     state_next = S_DONE;
                  end else begin
                     cnt_next = cnt_reg + LEN_W'(1);
                  end
               end
            end
            S_DONE: begin
               cnt_next   = '0;
               state_next = S_IDLE;
            end
            default: begin
               cnt_next   = '0;
               state_next = S_IDLE;
            end
         endcase
      end
   end

   // Output values are decoded from the upcoming state, so that the registered
   // outputs line up with the state register.
   always_comb begin
      busy_next     = (state_next != S_IDLE);
      done_next     = (state_next == S_DONE);
      tx_valid_next = (state_next == S_PRE) || (state_next == S_PAY) || (state_next == S_GUARD);
      m_load_next   = (state_next == S_LOAD);
      m_seed_next   = (state_next == S_LOAD) ? SEED : 3'b000;
      m_en_next     = (state_next == S_PAY);
      sym_cnt_next  = tx_valid_next ? cnt_next : '0;
      pre_i_next    = 2'b00;
      pre_q_next    = 2'b00;
      case (state_next)
         S_PRE:   sym_sel_next = 2'b01;
         S_PAY:   sym_sel_next = 2'b10;
         S_GUARD: sym_sel_next = 2'b11;
         default: sym_sel_next = 2'b00;
      endcase
      // The preamble alternates between (11,00) and (00,11) according to the symbol parity.
      if (state_next == S_PRE) begin
         pre_i_next = cnt_next[0] ? 2'b00 : 2'b11;
         pre_q_next = cnt_next[0] ? 2'b11 : 2'b00;
      end
   end

   // State register and registered outputs, with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         len_reg   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         tx_valid  <= 1'b0;
         sym_sel   <= 2'b00;
         pre_i     <= 2'b00;
         pre_q     <= 2'b00;
         m_load    <= 1'b0;
         m_seed    <= 3'b000;
         m_en      <= 1'b0;
         sym_cnt   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         len_reg   <= len_next;
         busy      <= busy_next;
         done      <= done_next;
         tx_valid  <= tx_valid_next;
         sym_sel   <= sym_sel_next;
         pre_i     <= pre_i_next;
         pre_q     <= pre_q_next;
         m_load    <= m_load_next;
         m_seed    <= m_seed_next;
         m_en      <= m_en_next;
         sym_cnt   <= sym_cnt_next;
      end
   end

endmodule
